// File: rtl/slot_alloc_pkg.sv
// Shared types and sizing for the slot allocator: slot id type, FSM states,
// and the default slot count.
package slot_alloc_pkg;

  localparam int SLOT_WIDTH_LOG = 4;
  localparam int NUM_SLOTS      = 1 << SLOT_WIDTH_LOG;

  typedef logic [SLOT_WIDTH_LOG-1:0] slot_id_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/slot_allocator_ffs.sv
// Find-first-set over a 2**WIDTH_LOG bit vector: lowest and highest set
// index, plus a flag for the all-zero vector.
module ffs #(
  parameter int WIDTH_LOG = 4
) (
  input  logic [(1<<WIDTH_LOG)-1:0] vec,
  output logic [WIDTH_LOG-1:0]      lsb,
  output logic [WIDTH_LOG-1:0]      msb,
  output logic                      zero
);

  localparam int N = 1 << WIDTH_LOG;

  // NOTE: every output gets a default before the loops, so no latch is inferred.
  always_comb begin
    lsb = '0;
    msb = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) lsb = WIDTH_LOG'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (vec[i]) msb = WIDTH_LOG'(i);
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/slot_allocator.sv
// Bitmap free-list slot allocator: offers the lowest free slot through a
// registered valid/ready output and accepts slot returns with double-free detection.
module slot_allocator
  import slot_alloc_pkg::*;
#(
  parameter int WIDTH_LOG = SLOT_WIDTH_LOG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  output logic                 alloc_valid,
  output logic [WIDTH_LOG-1:0] alloc_id,
  input  logic                 alloc_ready,
  input  logic                 free_valid,
  input  logic [WIDTH_LOG-1:0] free_id,
  output logic [WIDTH_LOG:0]   num_alloc,
  output logic                 full,
  output logic                 err_double_free
);

  localparam int SLOTS = 1 << WIDTH_LOG;

  state_t               state;
  logic [SLOTS-1:0]     bitmap;
  logic [SLOTS-1:0]     bitmap_next;
  logic [WIDTH_LOG-1:0] lsb;
  logic [WIDTH_LOG-1:0] msb_unused;
  logic                 zero;
  logic                 run;
  logic                 handshake;
  logic                 free_ok;
  logic                 prefetch;

  ffs #(.WIDTH_LOG(WIDTH_LOG)) u_ffs (
    .vec  (bitmap),
    .lsb  (lsb),
    .msb  (msb_unused),
    .zero (zero)
  );

  assign run       = (state == ST_RUN);
  assign handshake = alloc_valid & alloc_ready;
  // The held slot is off the bitmap but not yet owned by anyone, so freeing it is an error.
  assign free_ok   = free_valid & ~bitmap[free_id] & ~(alloc_valid && (alloc_id == free_id));
  assign prefetch  = run & (~alloc_valid | handshake) & ~zero;
  assign full      = (num_alloc == (WIDTH_LOG+1)'(SLOTS));

  // Prefetch clears a set bit and a valid free sets a clear bit, so they never collide.
  always_comb begin
    bitmap_next = bitmap;
    if (prefetch) bitmap_next[lsb] = 1'b0;
    if (free_ok) bitmap_next[free_id] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state           <= ST_INIT;
      bitmap          <= '1;
      alloc_valid     <= 1'b0;
      alloc_id        <= '0;
      num_alloc       <= '0;
      err_double_free <= 1'b0;
    end else if (state == ST_INIT) begin
      state <= ST_RUN;
    end else begin
      bitmap <= bitmap_next;
      if (prefetch) begin
        alloc_valid <= 1'b1;
        alloc_id    <= lsb;
      end else if (handshake) begin
        alloc_valid <= 1'b0;
      end
      if (handshake && !free_ok) begin
        num_alloc <= num_alloc + (WIDTH_LOG+1)'(1);
      end else if (!handshake && free_ok) begin
        num_alloc <= num_alloc - (WIDTH_LOG+1)'(1);
      end
      if (free_valid && !free_ok) err_double_free <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator: directed vector table, hand-written
// corner sequences, and random traffic against an ownership-set reference model.
module tb_slot_allocator;
  import slot_alloc_pkg::*;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       alloc_ready = 1'b0;
  logic       free_valid = 1'b0;
  slot_id_t   free_id = '0;
  logic       alloc_valid;
  slot_id_t   alloc_id;
  logic [W:0] num_alloc;
  logic       full;
  logic       err_double_free;

  slot_allocator #(.WIDTH_LOG(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .alloc_valid     (alloc_valid),
    .alloc_id        (alloc_id),
    .alloc_ready     (alloc_ready),
    .free_valid      (free_valid),
    .free_id         (free_id),
    .num_alloc       (num_alloc),
    .full            (full),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which slots the consumer owns, plus the slot on offer.
  bit m_init;
  bit m_offer_v;
  int m_offer_id;
  bit m_owned[N];
  bit m_err;

  function automatic int m_num();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_owned[i]);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit hs, fok;
    int pick;
    if (rst || flush) begin
      m_init = 1; m_offer_v = 0; m_offer_id = 0; m_err = 0;
      for (int i = 0; i < N; i++) m_owned[i] = 0;
    end else if (m_init) begin
      m_init = 0;
    end else begin
      hs  = m_offer_v && alloc_ready;
      fok = free_valid && m_owned[int'(free_id)];
      pick = -1;
      for (int i = N - 1; i >= 0; i--)
        if (!m_owned[i] && !(m_offer_v && m_offer_id == i)) pick = i;
      if (hs) m_owned[m_offer_id] = 1;
      if (fok) m_owned[int'(free_id)] = 0;
      if (free_valid && !fok) m_err = 1;
      if ((!m_offer_v || hs) && pick >= 0) begin
        m_offer_v = 1; m_offer_id = pick;
      end else if (hs) begin
        m_offer_v = 0;
      end
    end
  endtask

  task automatic cmp_model();
    check("model_valid", alloc_valid, m_offer_v);
    if (m_offer_v) check("model_id", alloc_id, m_offer_id);
    check("model_num", num_alloc, m_num());
    check("model_full", full, m_num() == N);
    check("model_err", err_double_free, m_err);
  endtask

  task automatic tick();
    cmp_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; alloc_ready = 0; free_valid = 0; free_id = '0;
    repeat (2) begin
      model_edge();
      @(posedge clk);
      #1;
    end
    rst = 0;
  endtask

  typedef struct {
    bit         flush;
    bit         ready;
    bit         fv;
    slot_id_t   fid;
    bit         ev;
    slot_id_t   eid;
    logic [W:0] enm;
    bit         eerr;
  } vec_t;

  vec_t vt[11];

  initial begin
    // Each row: inputs applied this cycle, outputs expected this cycle.
    vt[0]  = '{0, 0, 0, 4'd0, 0, 4'd0, 5'd0, 0};
    vt[1]  = '{0, 0, 0, 4'd0, 0, 4'd0, 5'd0, 0};
    vt[2]  = '{0, 0, 0, 4'd0, 1, 4'd0, 5'd0, 0};
    vt[3]  = '{0, 0, 1, 4'd0, 1, 4'd0, 5'd0, 0};
    vt[4]  = '{0, 0, 0, 4'd0, 1, 4'd0, 5'd0, 1};
    vt[5]  = '{0, 1, 0, 4'd0, 1, 4'd0, 5'd0, 1};
    vt[6]  = '{0, 1, 0, 4'd0, 1, 4'd1, 5'd1, 1};
    vt[7]  = '{1, 0, 0, 4'd0, 1, 4'd2, 5'd2, 1};
    vt[8]  = '{0, 0, 0, 4'd0, 0, 4'd0, 5'd0, 0};
    vt[9]  = '{0, 0, 0, 4'd0, 0, 4'd0, 5'd0, 0};
    vt[10] = '{0, 0, 0, 4'd0, 1, 4'd0, 5'd0, 0};

    // Table: stall, free of the held slot, handshakes, flush.
    do_reset();
    for (int r = 0; r < 11; r++) begin
      flush = vt[r].flush; alloc_ready = vt[r].ready;
      free_valid = vt[r].fv; free_id = vt[r].fid;
      check($sformatf("vec%0d_valid", r), alloc_valid, vt[r].ev);
      if (vt[r].ev) check($sformatf("vec%0d_id", r), alloc_id, vt[r].eid);
      check($sformatf("vec%0d_num", r), num_alloc, vt[r].enm);
      check($sformatf("vec%0d_err", r), err_double_free, vt[r].eerr);
      tick();
    end
    flush = 0; free_valid = 0;

    // Drain all slots back to back, then a free from the exhausted state.
    do_reset();
    alloc_ready = 1;
    check("rst_valid", alloc_valid, 0);
    check("rst_full", full, 0);
    tick(); tick();
    for (int i = 0; i < N; i++) begin
      check("drain_valid", alloc_valid, 1);
      check("drain_id", alloc_id, i);
      tick();
    end
    check("exhaust_valid", alloc_valid, 0);
    check("exhaust_full", full, 1);
    check("exhaust_num", num_alloc, 16);
    free_valid = 1; free_id = 4'd9;
    tick();
    free_valid = 0;
    check("free9_full", full, 0);
    check("free9_num", num_alloc, 15);
    check("free9_valid_t1", alloc_valid, 0);
    tick();
    check("free9_valid_t2", alloc_valid, 1);
    check("free9_id_t2", alloc_id, 9);
    tick();
    check("refill_num", num_alloc, 16);
    check("refill_full", full, 1);

    // Same-cycle handshake and free of slot 3 at num_alloc=4.
    do_reset();
    alloc_ready = 1;
    repeat (6) tick();
    check("pre_num4", num_alloc, 4);
    check("pre_id4", alloc_id, 4);
    free_valid = 1; free_id = 4'd3;
    tick();
    free_valid = 0;
    check("same_num", num_alloc, 4);
    check("same_id5", alloc_id, 5);
    tick();
    check("reuse_id3", alloc_id, 3);
    check("reuse_num", num_alloc, 5);
    alloc_ready = 0;
    free_valid = 1; free_id = 4'd12;
    tick();
    free_valid = 0;
    check("dbl12_err", err_double_free, 1);
    repeat (3) tick();
    check("dbl12_sticky", err_double_free, 1);
    check("dbl12_num", num_alloc, 5);
    flush = 1;
    tick();
    flush = 0;
    check("flush_err_clr", err_double_free, 0);

    // Flush with 7 allocated.
    do_reset();
    alloc_ready = 1;
    repeat (9) tick();
    check("pre_flush_num7", num_alloc, 7);
    flush = 1;
    tick();
    flush = 0;
    check("flush_valid", alloc_valid, 0);
    check("flush_num", num_alloc, 0);
    tick();
    check("flush_valid_c1", alloc_valid, 0);
    tick();
    check("flush_valid_c2", alloc_valid, 1);
    check("flush_id_c2", alloc_id, 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int f;
      alloc_ready = ($urandom_range(0, 3) != 0);
      free_valid  = ($urandom_range(0, 2) == 0);
      f = $urandom_range(0, N - 1);
      if ($urandom_range(0, 4) != 0) begin
        for (int k = 0; k < N; k++)
          if (m_owned[(f + k) % N]) begin
            f = (f + k) % N;
            break;
          end
      end
      free_id = slot_id_t'(f);
      flush = ($urandom_range(0, 149) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; flush = 0; free_valid = 0;
    cmp_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
